// File: rtl/microprocessor_mc_if.sv
// Instruction-ROM and data-SRAM bus between the multicycle core (master)
// and its memories (slave).
interface microprocessor_mc_if #(
  parameter int N                = 8,
  parameter int RF_addressBits   = 3,
  parameter int ROM_addressBits  = 6,
  parameter int SRAM_addressBits = 8
);
  logic [4+2*RF_addressBits+N-1:0] ROM_data;
  logic                            ROM_readEnable;
  logic [ROM_addressBits-1:0]      ROM_address;
  logic                            SRAM_req;
  logic                            SRAM_writeEnable;
  logic [SRAM_addressBits-1:0]     SRAM_address;
  logic [N-1:0]                    SRAM_data_in;
  logic [N-1:0]                    SRAM_data;
  logic                            SRAM_ack;

  modport master (
    input  ROM_data, SRAM_data, SRAM_ack,
    output ROM_readEnable, ROM_address, SRAM_req, SRAM_writeEnable,
           SRAM_address, SRAM_data_in
  );

  modport slave (
    output ROM_data, SRAM_data, SRAM_ack,
    input  ROM_readEnable, ROM_address, SRAM_req, SRAM_writeEnable,
           SRAM_address, SRAM_data_in
  );
endinterface

// File: rtl/microprocessor_mc.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM core with a 16-opcode ISA, a
// parametrised register file and a request/acknowledge data-memory port.
module microprocessor_mc #(
  parameter int N                = 8,
  parameter int RF_addressBits   = 3,
  parameter int ROM_addressBits  = 6,
  parameter int SRAM_addressBits = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  microprocessor_mc_if.master  bus,
  output logic [2:0]           ONZ,
  output logic                 halted,
  output logic                 overflowPC
);
  localparam int IW   = 4 + 2*RF_addressBits + N;
  localparam int NREG = 2**RF_addressBits;
  localparam int RB   = RF_addressBits;
  localparam int PB   = ROM_addressBits;

  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] EXECUTE = 3'd2;
  localparam logic [2:0] MEM     = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_LI   = 4'd8;
  localparam logic [3:0] OP_LD   = 4'd9;
  localparam logic [3:0] OP_ST   = 4'd10;
  localparam logic [3:0] OP_BRZ  = 4'd11;
  localparam logic [3:0] OP_BRN  = 4'd12;
  localparam logic [3:0] OP_BRO  = 4'd13;
  localparam logic [3:0] OP_JMP  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  logic [2:0]    state_reg, state_next;
  logic [PB-1:0] pc_reg, pc_next;
  logic [IW-1:0] ir_reg, ir_next;
  logic [2:0]    onz_reg, onz_next;
  logic          halted_reg, halted_next;
  logic          ovf_reg, ovf_next;
  logic [N-1:0]  rf_reg [NREG];

  logic          rf_we;
  logic [RB-1:0] rf_wa;
  logic [N-1:0]  rf_wd;
  logic [NREG-1:0] rf_wen;

  logic [3:0]    op;
  logic [RB-1:0] ra, rb;
  logic [N-1:0]  imm, a_val, b_val;
  logic [N-1:0]  alu_res;
  logic          alu_o;
  logic [PB:0]   pc_sum;
  logic          in_mem;

  assign op     = ir_reg[IW-1 -: 4];
  assign ra     = ir_reg[N+2*RB-1 -: RB];
  assign rb     = ir_reg[N+RB-1 -: RB];
  assign imm    = ir_reg[N-1:0];
  assign a_val  = rf_reg[ra];
  assign b_val  = rf_reg[rb];
  assign pc_sum = {1'b0, pc_reg} + {{PB{1'b0}}, 1'b1};
  assign in_mem = (state_reg == MEM);

  always_comb begin
    alu_res = '0;
    alu_o   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = a_val + b_val;
        alu_o   = (a_val[N-1] == b_val[N-1]) && (alu_res[N-1] != a_val[N-1]);
      end
      OP_SUB: begin
        alu_res = a_val - b_val;
        alu_o   = (a_val[N-1] != b_val[N-1]) && (alu_res[N-1] != a_val[N-1]);
      end
      OP_AND:  alu_res = a_val & b_val;
      OP_OR:   alu_res = a_val | b_val;
      OP_XOR:  alu_res = a_val ^ b_val;
      OP_NOT:  alu_res = ~b_val;
      OP_MOV:  alu_res = b_val;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    logic advance;
    logic jump;
    state_next  = state_reg;
    pc_next     = pc_reg;
    ir_next     = ir_reg;
    onz_next    = onz_reg;
    halted_next = halted_reg;
    ovf_next    = ovf_reg;
    rf_we       = 1'b0;
    rf_wa       = ra;
    rf_wd       = alu_res;
    advance     = 1'b0;
    jump        = 1'b0;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        ir_next    = bus.ROM_data;
        state_next = EXECUTE;
      end
      EXECUTE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
            rf_we    = 1'b1;
            onz_next = {alu_o, alu_res[N-1], alu_res == '0};
            advance  = 1'b1;
          end
          OP_LI: begin
            rf_we   = 1'b1;
            rf_wd   = imm;
            advance = 1'b1;
          end
          OP_LD, OP_ST: state_next = MEM;
          OP_BRZ: begin jump = onz_reg[0];  advance = !onz_reg[0]; end
          OP_BRN: begin jump = onz_reg[1];  advance = !onz_reg[1]; end
          OP_BRO: begin jump = onz_reg[2];  advance = !onz_reg[2]; end
          OP_JMP: jump = 1'b1;
          OP_HALT: begin
            state_next  = HALT;
            halted_next = 1'b1;
          end
          default: advance = 1'b1;
        endcase
      end
      MEM: begin
        if (bus.SRAM_ack) begin
          if (op == OP_LD) begin
            rf_we = 1'b1;
            rf_wd = bus.SRAM_data;
          end
          advance = 1'b1;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase

    // Taken branches never count as overflow; only sequential increments do.
    if (jump) begin
      pc_next    = imm[PB-1:0];
      state_next = FETCH;
    end else if (advance) begin
      pc_next = pc_sum[PB-1:0];
      if (pc_sum[PB]) begin
        ovf_next    = 1'b1;
        halted_next = 1'b1;
        state_next  = HALT;
      end else begin
        state_next = FETCH;
      end
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_rf_wen
    assign rf_wen[gi] = rf_we && (rf_wa == RB'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FETCH;
      pc_reg     <= '0;
      ir_reg     <= '0;
      onz_reg    <= '0;
      halted_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      ir_reg     <= ir_next;
      onz_reg    <= onz_next;
      halted_reg <= halted_next;
      ovf_reg    <= ovf_next;
      for (int i = 0; i < NREG; i++) begin
        if (rf_wen[i]) rf_reg[i] <= rf_wd;
      end
    end
  end

  // Memory outputs are forced to zero outside MEM so the bus is quiet otherwise.
  assign bus.ROM_readEnable   = (state_reg == FETCH);
  assign bus.ROM_address      = pc_reg;
  assign bus.SRAM_req         = in_mem;
  assign bus.SRAM_writeEnable = in_mem && (op == OP_ST);
  assign bus.SRAM_address     = in_mem ? b_val[SRAM_addressBits-1:0] : '0;
  assign bus.SRAM_data_in     = in_mem ? a_val : '0;

  assign ONZ        = onz_reg;
  assign halted     = halted_reg;
  assign overflowPC = ovf_reg;
endmodule

// File: tb/tb_microprocessor_mc.sv
// Directed programs with hand-computed results for the multicycle core;
// register contents are observed through stores on the SRAM bus.
module tb_microprocessor_mc;
  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                         XOR_ = 4'd5, NOT_ = 4'd6, MOV = 4'd7, LI = 4'd8, LD = 4'd9,
                         ST = 4'd10, BRZ = 4'd11, BRN = 4'd12, BRO = 4'd13, JMP = 4'd14,
                         HLT = 4'd15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] onz;
  logic       halted;
  logic       overflow_pc;

  int errors = 0;
  int checks = 0;

  logic [17:0] rom [64];
  logic [7:0]  sram [256];
  int          ack_delay = 1;
  logic        ack_force = 1'b0;
  int          mem_cnt = 0;
  int          req_cycles = 0;
  int          stable_err = 0;
  logic [7:0]  first_addr, first_data;
  logic [7:0]  log_addr[$];
  logic [7:0]  log_data[$];
  logic [2:0]  log_onz[$];
  int          fetch_cnt = 0;
  logic [5:0]  watch_addr = 6'd0;
  int          cyc;

  microprocessor_mc_if #(.N(8), .RF_addressBits(3), .ROM_addressBits(6), .SRAM_addressBits(8)) bus ();

  microprocessor_mc #(.N(8), .RF_addressBits(3), .ROM_addressBits(6), .SRAM_addressBits(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ONZ        (onz),
    .halted     (halted),
    .overflowPC (overflow_pc)
  );

  always #5 clk = ~clk;

  initial begin
    bus.ROM_data  = '0;
    bus.SRAM_data = '0;
    bus.SRAM_ack  = 1'b0;
  end

  always @(posedge clk) begin
    if (bus.ROM_readEnable) bus.ROM_data <= rom[bus.ROM_address];
  end

  always @(negedge clk) begin
    if (bus.ROM_readEnable && bus.ROM_address == watch_addr) fetch_cnt++;
    if (bus.SRAM_req) begin
      mem_cnt++;
      req_cycles++;
      if (mem_cnt == 1) begin
        first_addr = bus.SRAM_address;
        first_data = bus.SRAM_data_in;
      end else if (bus.SRAM_address != first_addr || bus.SRAM_data_in != first_data) begin
        stable_err++;
      end
      if (mem_cnt == ack_delay) begin
        bus.SRAM_ack = 1'b1;
        if (bus.SRAM_writeEnable) begin
          sram[bus.SRAM_address] = bus.SRAM_data_in;
          log_addr.push_back(bus.SRAM_address);
          log_data.push_back(bus.SRAM_data_in);
          log_onz.push_back(onz);
          $display("mem ST addr=%02h data=%02h onz=%03b", bus.SRAM_address, bus.SRAM_data_in, onz);
        end else begin
          bus.SRAM_data = sram[bus.SRAM_address];
          $display("mem LD addr=%02h data=%02h", bus.SRAM_address, sram[bus.SRAM_address]);
        end
      end else begin
        bus.SRAM_ack = 1'b0;
      end
    end else begin
      mem_cnt = 0;
      bus.SRAM_ack = ack_force;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ins(input logic [3:0] op, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [7:0] imm);
    return {op, ra, rb, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = ins(NOP, 3'd0, 3'd0, 8'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
    log_onz.delete();
    req_cycles = 0;
    stable_err = 0;
    fetch_cnt  = 0;
  endtask

  task automatic run_until_halt(input int max, output int n);
    n = 0;
    while (!halted && n < max) begin
      tick();
      n++;
    end
    if (!halted) check("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_store(input string tag, input int idx, input logic [7:0] addr,
                             input logic [7:0] data, input logic [2:0] f);
    if (idx < log_addr.size()) begin
      check({tag, "_addr"}, 32'(log_addr[idx]), 32'(addr));
      check({tag, "_data"}, 32'(log_data[idx]), 32'(data));
      check({tag, "_onz"},  32'(log_onz[idx]),  32'(f));
    end else begin
      check({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int busy;
    for (int i = 0; i < 256; i++) sram[i] = 8'h00;

    // Test 1: exact program, reset outputs and halt timing
    clear_rom();
    rom[0] = ins(LI, 3'd1, 3'd0, 8'd5);
    rom[1] = ins(LI, 3'd2, 3'd0, 8'd3);
    rom[2] = ins(SUB, 3'd1, 3'd2, 8'd0);
    rom[3] = ins(HLT, 3'd0, 3'd0, 8'd0);
    reset_dut();
    check("rst_rom_re",   32'(bus.ROM_readEnable), 32'd1);
    check("rst_rom_addr", 32'(bus.ROM_address), 32'd0);
    check("rst_sram_req", 32'(bus.SRAM_req), 32'd0);
    check("rst_sram_we",  32'(bus.SRAM_writeEnable), 32'd0);
    check("rst_sram_adr", 32'(bus.SRAM_address), 32'd0);
    check("rst_sram_din", 32'(bus.SRAM_data_in), 32'd0);
    check("rst_onz",      32'(onz), 32'd0);
    check("rst_halted",   32'(halted), 32'd0);
    check("rst_ovf",      32'(overflow_pc), 32'd0);
    repeat (11) tick();
    check("p1_halt_c11", 32'(halted), 32'd0);
    tick();
    check("p1_halt_c12", 32'(halted), 32'd1);
    check("p1_onz", 32'(onz), 32'b000);
    check("p1_ovf", 32'(overflow_pc), 32'd0);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ROM_readEnable || bus.SRAM_req) busy++;
    end
    check("p1_frozen", 32'(busy), 32'd0);

    // Test 1b: same arithmetic, result stored to observe r1
    rom[3] = ins(ST, 3'd1, 3'd0, 8'd0);
    rom[4] = ins(HLT, 3'd0, 3'd0, 8'd0);
    ack_delay = 1;
    reset_dut();
    run_until_halt(200, cyc);
    check("p1b_cycles", 32'(cyc), 32'd16);
    check_store("p1b_r1", 0, 8'h00, 8'h02, 3'b000);

    // Test 2: overflow flags, conditional branches, SUB r,r
    clear_rom();
    rom[0]  = ins(LI,  3'd1, 3'd0, 8'h7F);
    rom[1]  = ins(LI,  3'd2, 3'd0, 8'h01);
    rom[2]  = ins(ADD, 3'd1, 3'd2, 8'h00);
    rom[3]  = ins(BRO, 3'd0, 3'd0, 8'd5);
    rom[4]  = ins(LI,  3'd1, 3'd0, 8'h00);
    rom[5]  = ins(BRN, 3'd0, 3'd0, 8'd7);
    rom[6]  = ins(LI,  3'd1, 3'd0, 8'h00);
    rom[7]  = ins(BRZ, 3'd0, 3'd0, 8'd9);
    rom[8]  = ins(ST,  3'd1, 3'd0, 8'h00);
    rom[9]  = ins(SUB, 3'd1, 3'd1, 8'h00);
    rom[10] = ins(ST,  3'd1, 3'd0, 8'h00);
    rom[11] = ins(HLT, 3'd0, 3'd0, 8'h00);
    reset_dut();
    run_until_halt(300, cyc);
    check_store("p2_add", 0, 8'h00, 8'h80, 3'b110);
    check_store("p2_sub", 1, 8'h00, 8'h00, 3'b001);
    check("p2_nstores", 32'(log_addr.size()), 32'd2);

    // Test 3: logic ops, MOV, NOT and O cleared by logic ops
    clear_rom();
    rom[0]  = ins(LI,   3'd5, 3'd0, 8'h7F);
    rom[1]  = ins(LI,   3'd6, 3'd0, 8'h01);
    rom[2]  = ins(ADD,  3'd5, 3'd6, 8'h00);
    rom[3]  = ins(LI,   3'd1, 3'd0, 8'hF0);
    rom[4]  = ins(LI,   3'd2, 3'd0, 8'h3C);
    rom[5]  = ins(MOV,  3'd3, 3'd1, 8'h00);
    rom[6]  = ins(AND_, 3'd3, 3'd2, 8'h00);
    rom[7]  = ins(ST,   3'd3, 3'd0, 8'h00);
    rom[8]  = ins(MOV,  3'd3, 3'd1, 8'h00);
    rom[9]  = ins(OR_,  3'd3, 3'd2, 8'h00);
    rom[10] = ins(ST,   3'd3, 3'd0, 8'h00);
    rom[11] = ins(MOV,  3'd3, 3'd1, 8'h00);
    rom[12] = ins(XOR_, 3'd3, 3'd2, 8'h00);
    rom[13] = ins(ST,   3'd3, 3'd0, 8'h00);
    rom[14] = ins(NOT_, 3'd3, 3'd2, 8'h00);
    rom[15] = ins(ST,   3'd3, 3'd0, 8'h00);
    rom[16] = ins(HLT,  3'd0, 3'd0, 8'h00);
    reset_dut();
    run_until_halt(300, cyc);
    check_store("p3_and", 0, 8'h00, 8'h30, 3'b000);
    check_store("p3_or",  1, 8'h00, 8'hFC, 3'b010);
    check_store("p3_xor", 2, 8'h00, 8'hCC, 3'b010);
    check_store("p3_not", 3, 8'h00, 8'hC3, 3'b010);

    // Test 4: ST/LD with a 4-cycle acknowledge
    clear_rom();
    rom[0] = ins(SUB, 3'd7, 3'd7, 8'h00);
    rom[1] = ins(LI,  3'd0, 3'd0, 8'h2A);
    rom[2] = ins(LI,  3'd3, 3'd0, 8'h10);
    rom[3] = ins(ST,  3'd0, 3'd3, 8'h00);
    rom[4] = ins(LD,  3'd4, 3'd3, 8'h00);
    rom[5] = ins(ST,  3'd4, 3'd5, 8'h00);
    rom[6] = ins(HLT, 3'd0, 3'd0, 8'h00);
    ack_delay = 4;
    reset_dut();
    run_until_halt(300, cyc);
    check("p4_cycles", 32'(cyc), 32'd33);
    check("p4_req_cycles", 32'(req_cycles), 32'd12);
    check("p4_stable", 32'(stable_err), 32'd0);
    check_store("p4_st", 0, 8'h10, 8'h2A, 3'b001);
    check_store("p4_ld", 1, 8'h00, 8'h2A, 3'b001);
    check("p4_onz", 32'(onz), 32'b001);
    ack_delay = 1;

    // Test 5: counter loop
    clear_rom();
    rom[0] = ins(LI,  3'd1, 3'd0, 8'd3);
    rom[1] = ins(LI,  3'd2, 3'd0, 8'd1);
    rom[2] = ins(SUB, 3'd1, 3'd2, 8'd0);
    rom[3] = ins(BRZ, 3'd0, 3'd0, 8'd6);
    rom[4] = ins(JMP, 3'd0, 3'd0, 8'd2);
    rom[6] = ins(ST,  3'd1, 3'd0, 8'd0);
    rom[7] = ins(HLT, 3'd0, 3'd0, 8'd0);
    watch_addr = 6'd2;
    reset_dut();
    run_until_halt(300, cyc);
    check("p5_cycles", 32'(cyc), 32'd37);
    check("p5_body", 32'(fetch_cnt), 32'd3);
    check_store("p5_r1", 0, 8'h00, 8'h00, 3'b001);

    // Test 6: PC overflow through a ROM full of NOP
    clear_rom();
    reset_dut();
    repeat (191) tick();
    check("p6_halt_c191", 32'(halted), 32'd0);
    check("p6_ovf_c191",  32'(overflow_pc), 32'd0);
    tick();
    check("p6_halt_c192", 32'(halted), 32'd1);
    check("p6_ovf_c192",  32'(overflow_pc), 32'd1);
    check("p6_pc",        32'(bus.ROM_address), 32'd0);
    check("p6_rom_re",    32'(bus.ROM_readEnable), 32'd0);

    // Test 7: JMP to the last address then a NOP overflows
    rom[0] = ins(JMP, 3'd0, 3'd0, 8'd63);
    reset_dut();
    repeat (3) tick();
    check("p7_jmp_pc",  32'(bus.ROM_address), 32'd63);
    check("p7_jmp_ovf", 32'(overflow_pc), 32'd0);
    repeat (3) tick();
    check("p7_ovf",  32'(overflow_pc), 32'd1);
    check("p7_halt", 32'(halted), 32'd1);
    check("p7_pc",   32'(bus.ROM_address), 32'd0);

    // Test 8: reset while a load waits for its acknowledge
    clear_rom();
    rom[0] = ins(LI, 3'd1, 3'd0, 8'd5);
    rom[1] = ins(LD, 3'd2, 3'd0, 8'd0);
    ack_delay = 1000;
    reset_dut();
    cyc = 0;
    while (!bus.SRAM_req && cyc < 50) begin
      tick();
      cyc++;
    end
    check("p8_in_mem", 32'(bus.SRAM_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_force = 1'b1;
    rom[0] = ins(ST,  3'd1, 3'd0, 8'd0);
    rom[1] = ins(HLT, 3'd0, 3'd0, 8'd0);
    log_addr.delete();
    log_data.delete();
    log_onz.delete();
    check("p8_req_low", 32'(bus.SRAM_req), 32'd0);
    check("p8_fetch",   32'(bus.ROM_readEnable), 32'd1);
    check("p8_pc",      32'(bus.ROM_address), 32'd0);
    check("p8_onz",     32'(onz), 32'd0);
    tick();
    ack_force = 1'b0;
    ack_delay = 1;
    check("p8_decode_re",  32'(bus.ROM_readEnable), 32'd0);
    check("p8_decode_req", 32'(bus.SRAM_req), 32'd0);
    run_until_halt(100, cyc);
    check_store("p8_rf_clear", 0, 8'h00, 8'h00, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
